data_mem_ctrl: RTL and testbench

Parametrised data memory for the multicycle CPU datapath. It generalises the single-cycle data memory in three ways:
- Configurable depth.
- Byte, halfword and word accesses, with sign or zero extension on loads.
- A programmable wait-state latency behind a valid/ready request and response handshake.

It sits between the load/store unit and the core stall logic. Misaligned and out-of-range accesses are flagged in the response and never touch storage.

---
 rtl/dmem_pkg.sv | 64 ++++++
 rtl/data_mem_ctrl_if.sv | 27 ++
 rtl/dmem_word_array.sv | 37 +++
 rtl/data_mem_ctrl.sv | 171 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings and byte-lane helpers for the data memory controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dmemState_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << offset;
      SZ_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Reserved size is reported as misaligned so it can never touch storage.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = offset[0];
      SZ_WORD: mis = |offset;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  // Replicating the right-aligned data lets the byte-enable pick the lane.
  function automatic logic [31:0] store_align(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] aligned;
    case (size)
      SZ_BYTE: aligned = {4{data[7:0]}};
      SZ_HALF: aligned = {2{data[15:0]}};
      default: aligned = data;
    endcase
    return aligned;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] offset, input logic isUnsigned);
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic [31:0] result;
    byteVal = word[{offset, 3'b000} +: 8];
    halfVal = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: result = isUnsigned ? {24'd0, byteVal} : {{24{byteVal[7]}}, byteVal};
      SZ_HALF: result = isUnsigned ? {16'd0, halfVal} : {{16{halfVal[15]}}, halfVal};
      SZ_WORD: result = word;
      default: result = 32'd0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the load/store unit and the data memory controller.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              rsp_valid;
  logic [31:0]       rdata;
  logic              err_misaligned;
  logic              err_range;
  logic              busy;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, addr, wdata,
    input  req_ready, rsp_valid, rdata, err_misaligned, err_range, busy
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, addr, wdata,
    output req_ready, rsp_valid, rdata, err_misaligned, err_range, busy
  );
endinterface

// File: rtl/dmem_word_array.sv
// Single-port word storage with byte-enable write, optional synchronous clear
// on reset and combinational read.
module dmem_word_array #(
  parameter int DEPTH_WORDS    = 256,
  parameter int CLEAR_ON_RESET = 1,
  parameter int IDX_W          = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrEn,
  input  logic [3:0]       byteEn,
  input  logic [IDX_W-1:0] wordIdx,
  input  logic [31:0]      wrData,
  output logic [31:0]      rdData
);
  logic [31:0] memR [DEPTH_WORDS];

  // Storage update: clear under reset when configured, byte-enabled write otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET != 0) begin
        for (int i = 0; i < DEPTH_WORDS; i++) begin
          memR[i] <= 32'd0;
        end
      end
    end else if (wrEn) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) begin
          memR[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
        end
      end
    end
  end

  assign rdData = memR[wordIdx];

endmodule

// File: rtl/data_mem_ctrl.sv
// Multicycle data memory controller: valid/ready FSM with programmable wait
// states, lane-aware loads and stores, and alignment/range error reporting.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DEPTH_WORDS    = 256,
  parameter int WAIT_CYCLES    = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_ctrl_if.slave bus
);
  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic       NO_WAIT   = (WAIT_CYCLES == 0);

  dmemState_e        stateR;
  logic [3:0]        waitCntR;
  logic              writeR;
  logic [1:0]        sizeR;
  logic              unsR;
  logic [ADDR_W-1:0] addrR;
  logic [31:0]       wdataR;

  logic              reqReadyR;
  logic              rspValidR;
  logic [31:0]       rdataR;
  logic              errMisR;
  logic              errRangeR;
  logic              busyR;

  logic              selWriteS;
  logic [1:0]        selSizeS;
  logic              selUnsS;
  logic [ADDR_W-1:0] selAddrS;
  logic [31:0]       selWdataS;
  logic              misS;
  logic              rangeS;
  logic              errS;
  logic              enterRespS;
  logic              commitS;
  logic [31:0]       memRdataS;
  logic [31:0]       rspDataS;

  // Request source: live bus fields at the accept edge, latched copy afterwards
  always_comb begin
    if (stateR == ST_IDLE) begin
      selWriteS = bus.req_write;
      selSizeS  = bus.req_size;
      selUnsS   = bus.req_unsigned;
      selAddrS  = bus.addr;
      selWdataS = bus.wdata;
    end else begin
      selWriteS = writeR;
      selSizeS  = sizeR;
      selUnsS   = unsR;
      selAddrS  = addrR;
      selWdataS = wdataR;
    end
  end

  assign misS       = is_misaligned(selSizeS, selAddrS[1:0]);
  assign rangeS     = |selAddrS[ADDR_W-1:IDX_W+2];
  assign errS       = misS | rangeS;
  assign enterRespS = ((stateR == ST_IDLE) && bus.req_valid && (errS || NO_WAIT)) ||
                      ((stateR == ST_WAIT) && (waitCntR == 4'd0));
  assign commitS    = enterRespS && selWriteS && !errS;
  assign rspDataS   = (errS || selWriteS) ? 32'd0
                    : load_extend(memRdataS, selSizeS, selAddrS[1:0], selUnsS);

  dmem_word_array #(
    .DEPTH_WORDS   (DEPTH_WORDS),
    .CLEAR_ON_RESET(CLEAR_ON_RESET),
    .IDX_W         (IDX_W)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .wrEn   (commitS),
    .byteEn (lane_mask(selSizeS, selAddrS[1:0])),
    .wordIdx(selAddrS[IDX_W+1:2]),
    .wrData (store_align(selSizeS, selWdataS)),
    .rdData (memRdataS)
  );

  // Access FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateR    <= ST_IDLE;
      waitCntR  <= 4'd0;
      writeR    <= 1'b0;
      sizeR     <= 2'b00;
      unsR      <= 1'b0;
      addrR     <= '0;
      wdataR    <= 32'd0;
      reqReadyR <= 1'b1;
      rspValidR <= 1'b0;
      rdataR    <= 32'd0;
      errMisR   <= 1'b0;
      errRangeR <= 1'b0;
      busyR     <= 1'b0;
    end else begin
      case (stateR)
        ST_IDLE: begin
          rspValidR <= 1'b0;
          rdataR    <= 32'd0;
          errMisR   <= 1'b0;
          errRangeR <= 1'b0;
          if (bus.req_valid) begin
            writeR    <= bus.req_write;
            sizeR     <= bus.req_size;
            unsR      <= bus.req_unsigned;
            addrR     <= bus.addr;
            wdataR    <= bus.wdata;
            reqReadyR <= 1'b0;
            busyR     <= 1'b1;
            if (enterRespS) begin
              stateR    <= ST_RESP;
              rspValidR <= 1'b1;
              rdataR    <= rspDataS;
              errMisR   <= misS;
              errRangeR <= rangeS;
            end else begin
              stateR   <= ST_WAIT;
              waitCntR <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (waitCntR == 4'd0) begin
            stateR    <= ST_RESP;
            rspValidR <= 1'b1;
            rdataR    <= rspDataS;
            errMisR   <= misS;
            errRangeR <= rangeS;
          end else begin
            waitCntR <= waitCntR - 4'd1;
          end
        end
        ST_RESP: begin
          stateR    <= ST_IDLE;
          rspValidR <= 1'b0;
          rdataR    <= 32'd0;
          errMisR   <= 1'b0;
          errRangeR <= 1'b0;
          busyR     <= 1'b0;
          reqReadyR <= 1'b1;
        end
        default: begin
          stateR    <= ST_IDLE;
          waitCntR  <= 4'd0;
          rspValidR <= 1'b0;
          rdataR    <= 32'd0;
          errMisR   <= 1'b0;
          errRangeR <= 1'b0;
          busyR     <= 1'b0;
          reqReadyR <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready      = reqReadyR;
  assign bus.rsp_valid      = rspValidR;
  assign bus.rdata          = rdataR;
  assign bus.err_misaligned = errMisR;
  assign bus.err_range      = errRangeR;
  assign bus.busy           = busyR;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: three instances (WAIT 1/0/3, clear on/on/off)
// driven with directed accesses; a negedge monitor checks every response.
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        em;
    logic        er;
    int          cyc;
  } expT;

  logic        clk;
  logic [2:0]  rstN;
  logic        vld [3];
  logic        wr  [3];
  logic [1:0]  sz  [3];
  logic        uns [3];
  logic [31:0] ad  [3];
  logic [31:0] wd  [3];
  logic [2:0]  rdy, rv, bz, em, er;
  logic [2:0][31:0] rd;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  expT sbq[$];

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int WC  = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    localparam int CLR = (g == 2) ? 0 : 1;
    data_mem_ctrl_if #(.ADDR_W(32)) ifc ();
    assign ifc.req_valid    = vld[g];
    assign ifc.req_write    = wr[g];
    assign ifc.req_size     = sz[g];
    assign ifc.req_unsigned = uns[g];
    assign ifc.addr         = ad[g];
    assign ifc.wdata        = wd[g];
    assign rdy[g] = ifc.req_ready;
    assign rv[g]  = ifc.rsp_valid;
    assign bz[g]  = ifc.busy;
    assign em[g]  = ifc.err_misaligned;
    assign er[g]  = ifc.err_range;
    assign rd[g]  = ifc.rdata;
    data_mem_ctrl #(
      .ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(WC), .CLEAR_ON_RESET(CLR)
    ) dut (
      .clk(clk), .rst_n(rstN[g]), .bus(ifc.slave)
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wcOf(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  function automatic void chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%h expected=%h", nm, k, act, exp);
    end
  endfunction

  function automatic int pending(input int k);
    int n = 0;
    foreach (sbq[i]) if (sbq[i].inst == k) n++;
    return n;
  endfunction

  // Scoreboard monitor: each response pulse pops the oldest expectation of its instance
  always @(negedge clk) begin : monitor
    int idx;
    for (int k = 0; k < 3; k++) begin
      if (rv[k] === 1'b1) begin
        idx = -1;
        for (int i = 0; i < sbq.size(); i++) if (idx < 0 && sbq[i].inst == k) idx = i;
        if (idx < 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp inst=%0d actual=rsp_valid expected=none rdata=%h", k, rd[k]);
        end else begin
          chk("rsp_rdata", k, rd[k], sbq[idx].rdata);
          chk("rsp_err_misaligned", k, 32'(em[k]), 32'(sbq[idx].em));
          chk("rsp_err_range", k, 32'(er[k]), 32'(sbq[idx].er));
          chk("rsp_latency_cycle", k, 32'(cyc), 32'(sbq[idx].cyc));
          sbq.delete(idx);
        end
      end
    end
  end

  task automatic drive(input int k, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d, output bit acc, output int accEdge);
    vld[k] = 1'b1; wr[k] = w; sz[k] = s; uns[k] = u; ad[k] = a; wd[k] = d;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk);
      acc = rdy[k];
      @(posedge clk);
    end
    #1;
    vld[k] = 1'b0;
    accEdge = cyc;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout inst=%0d actual=no_accept expected=accept", k);
    end
  endtask

  task automatic drain(input int k);
    int n = 0;
    while (pending(k) > 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (pending(k) > 0) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout inst=%0d actual=pending%0d expected=0", k, pending(k));
      for (int i = sbq.size() - 1; i >= 0; i--) if (sbq[i].inst == k) sbq.delete(i);
    end
    #1;
  endtask

  task automatic access(input int k, input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] expRd, input logic expM, input logic expR);
    bit  acc;
    int  accEdge;
    expT e;
    drive(k, w, s, u, a, d, acc, accEdge);
    if (acc) begin
      e.inst = k; e.rdata = expRd; e.em = expM; e.er = expR;
      e.cyc = accEdge + ((expM || expR) ? 0 : wcOf(k));
      sbq.push_back(e);
      drain(k);
    end
  endtask

  task automatic checkIdleOutputs(input int k, input string tag);
    chk({tag, "_req_ready"}, k, 32'(rdy[k]), 32'd1);
    chk({tag, "_rsp_valid"}, k, 32'(rv[k]), 32'd0);
    chk({tag, "_busy"}, k, 32'(bz[k]), 32'd0);
    chk({tag, "_rdata"}, k, rd[k], 32'd0);
    chk({tag, "_err_mis"}, k, 32'(em[k]), 32'd0);
    chk({tag, "_err_range"}, k, 32'(er[k]), 32'd0);
  endtask

  task automatic abortStore(input int k, input logic [31:0] a, input logic [31:0] d);
    bit acc;
    int accEdge;
    drive(k, 1'b1, SZ_WORD, 1'b0, a, d, acc, accEdge);
    if (acc) begin
      rstN[k] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkIdleOutputs(k, "abort");
      rstN[k] = 1'b1;
      repeat (wcOf(k) + 4) @(posedge clk);
      #1;
    end
  endtask

  // Hold req_valid high with a word store and track accept spacing and busy/ready
  task automatic holdRun(input int k, input int nAcc, input logic [31:0] d);
    int  first = -1;
    int  lastAcc = -1;
    int  accs = 0;
    int  wc = wcOf(k);
    int  phase;
    expT e;
    vld[k] = 1'b1; wr[k] = 1'b1; sz[k] = SZ_WORD; uns[k] = 1'b0; ad[k] = 32'h20; wd[k] = d;
    for (int n = 0; n < 60 && accs < nAcc; n++) begin
      @(negedge clk);
      if (first >= 0) begin
        phase = (cyc - first) % (wc + 2);
        chk("hold_busy", k, 32'(bz[k]), (phase <= wc) ? 32'd1 : 32'd0);
        chk("hold_req_ready", k, 32'(rdy[k]), (phase == wc + 1) ? 32'd1 : 32'd0);
      end
      if (rdy[k] === 1'b1) begin
        if (first < 0) first = cyc + 1;
        else chk("accept_spacing", k, 32'(cyc + 1 - lastAcc), 32'(wc + 2));
        lastAcc = cyc + 1;
        e.inst = k; e.rdata = 32'd0; e.em = 1'b0; e.er = 1'b0; e.cyc = cyc + 1 + wc;
        sbq.push_back(e);
        accs++;
      end
    end
    @(posedge clk);
    #1;
    vld[k] = 1'b0;
    if (accs < nAcc) begin
      checks++;
      failures++;
      $display("FAIL hold_accepts inst=%0d actual=%0d expected=%0d", k, accs, nAcc);
    end
    drain(k);
  endtask

  initial begin
    clk = 1'b0;
    rstN = 3'b000;
    for (int k = 0; k < 3; k++) begin
      vld[k] = 1'b0; wr[k] = 1'b0; sz[k] = SZ_WORD; uns[k] = 1'b0; ad[k] = 32'd0; wd[k] = 32'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) checkIdleOutputs(k, "reset");
    @(posedge clk);
    #1;
    rstN = 3'b111;

    // Word store then load on WAIT_CYCLES=1
    access(0, 1'b1, SZ_WORD, 1'b0, 32'h4, 32'hAAAA_AAAA, 32'h0, 1'b0, 1'b0);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 32'hAAAA_AAAA, 1'b0, 1'b0);

    // Byte merge and sign/zero extension
    access(0, 1'b1, SZ_WORD, 1'b0, 32'h8, 32'h1122_3344, 32'h0, 1'b0, 1'b0);
    access(0, 1'b1, SZ_BYTE, 1'b0, 32'hA, 32'h0000_00FF, 32'h0, 1'b0, 1'b0);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 32'h11FF_3344, 1'b0, 1'b0);
    access(0, 1'b0, SZ_BYTE, 1'b0, 32'hA, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    access(0, 1'b0, SZ_BYTE, 1'b1, 32'hA, 32'h0, 32'h0000_00FF, 1'b0, 1'b0);
    access(0, 1'b0, SZ_HALF, 1'b0, 32'h8, 32'h0, 32'h0000_3344, 1'b0, 1'b0);
    access(0, 1'b0, SZ_HALF, 1'b0, 32'hA, 32'h0, 32'h0000_11FF, 1'b0, 1'b0);

    // Misalignment, reserved size, and a blocked misaligned store
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 1'b0);
    access(0, 1'b0, SZ_HALF, 1'b0, 32'h3, 32'h0, 32'h0, 1'b1, 1'b0);
    access(0, 1'b0, 2'b11, 1'b0, 32'h4, 32'h0, 32'h0, 1'b1, 1'b0);
    access(0, 1'b1, SZ_WORD, 1'b0, 32'h6, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 32'hAAAA_AAAA, 1'b0, 1'b0);

    // Range boundary and combined errors
    access(0, 1'b1, SZ_WORD, 1'b0, 32'h400, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h3FC, 32'h0, 32'h0, 1'b0, 1'b0);
    access(0, 1'b1, SZ_WORD, 1'b0, 32'h402, 32'h1234_5678, 32'h0, 1'b1, 1'b1);

    // Back-to-back spacing with WAIT_CYCLES=0 and 3
    holdRun(1, 3, 32'h1357_9BDF);
    access(1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h1357_9BDF, 1'b0, 1'b0);
    holdRun(2, 3, 32'h2468_ACE0);
    access(2, 1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0, 32'h0000_2468, 1'b0, 1'b0);

    // Reset during WAIT aborts the store
    abortStore(0, 32'h10, 32'h5555_5555);
    access(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);
    access(2, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);
    abortStore(2, 32'h10, 32'h5555_5555);
    access(2, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);
    access(2, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'h2468_ACE0, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover_expectations actual=%0d expected=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
